// File: rtl/pdec_defs_pkg.sv
// Shared types for the pdec sequencer: decoder configuration word, PLUT size and FSM states.
package pdec_defs;

  localparam int PLUT_ENTRIES = 32;
  localparam int PLUT_AW      = $clog2(PLUT_ENTRIES);

  typedef struct packed {
    logic [2:0] bpp;
    logic       lrform;
    logic       packed_en;
    logic       bgnd;
    logic [1:0] pluta;
  } pdec;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } pdec_ctrl_state_e;

endpackage

// File: rtl/pdec_plut_rf.sv
// 32x16 PLUT register file: one write port, every entry visible in parallel.
module pdec_plut_rf
  import pdec_defs::*;
(
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           wr_en,
  input  logic [PLUT_AW-1:0]             wr_addr,
  input  logic [15:0]                    wr_data,
  output logic [PLUT_ENTRIES-1:0][15:0]  rd_data
);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_data <= '0;
    end else if (wr_en) begin
      rd_data[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pdec_ctrl.sv
// Sequencer for the pdec pixel decoder: one pixel in flight at a time, results
// returned on a valid/ready stream, with a bounded wait for the decoder.
module pdec_ctrl
  import pdec_defs::*;
#(
  parameter int PDEC_LAT   = 2,
  parameter int TMO_CYCLES = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  pdec                           cfg_pdec,
  input  logic [31:0]                   cfg_pre0,
  input  logic                          plut_wr_en,
  input  logic [PLUT_AW-1:0]            plut_wr_addr,
  input  logic [15:0]                   plut_wr_data,
  output logic                          plut_wr_ready,
  input  logic                          s_pix_valid,
  output logic                          s_pix_ready,
  input  logic [15:0]                   s_pix_data,
  input  logic                          s_pix_last,
  input  logic                          abort,
  output logic [15:0]                   pdec_pixel,
  output pdec                           pdec_cfg,
  output logic [31:0]                   pdec_pre0,
  output logic [PLUT_ENTRIES-1:0][15:0] pdec_plut,
  input  logic                          pdec_busy,
  input  logic                          pdec_data_ready,
  input  logic [15:0]                   pdec_amv,
  input  logic [15:0]                   pdec_pres,
  input  logic                          pdec_transparent,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [15:0]                   m_amv,
  output logic [15:0]                   m_pres,
  output logic                          m_transparent,
  output logic                          m_last,
  output logic                          busy,
  output logic                          cel_done,
  output logic                          err_timeout
);

  localparam int TMO_LIMIT = PDEC_LAT + TMO_CYCLES - 1;
  localparam int CNT_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_RDY = CNT_W'(PDEC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TMO_LIMIT);

  pdec_ctrl_state_e state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             last_p0;
  logic             cfg_hs, pix_hs, plut_we;
  logic             cap_rdy, cap_tmo, capture;
  logic             unused_pdec_busy;

  // The decoder's busy status carries no information beyond data_ready here.
  assign unused_pdec_busy = pdec_busy;

  assign cfg_hs  = (state == ST_IDLE) && cfg_valid;
  assign pix_hs  = s_pix_ready && s_pix_valid;
  assign plut_we = plut_wr_ready && plut_wr_en;
  assign cap_rdy = (state == ST_WAIT) && (wait_cnt >= CNT_RDY) && pdec_data_ready;
  assign cap_tmo = (state == ST_WAIT) && (wait_cnt == CNT_TMO) && !pdec_data_ready;
  assign capture = (cap_rdy || cap_tmo) && !abort;

  pdec_plut_rf u_plut (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (plut_we),
    .wr_addr (plut_wr_addr),
    .wr_data (plut_wr_data),
    .rd_data (pdec_plut)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (cfg_valid)           state_n = ST_LOAD;
      ST_LOAD: if (s_pix_valid)         state_n = ST_WAIT;
      ST_WAIT: if (cap_rdy || cap_tmo)  state_n = ST_EMIT;
      ST_EMIT: if (m_ready)             state_n = m_last ? ST_DONE : ST_LOAD;
      ST_DONE:                          state_n = ST_IDLE;
      default:                          state_n = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_n = ST_IDLE;
  end

  // Control: status outputs are registered decodes of the next state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      cfg_ready     <= 1'b1;
      plut_wr_ready <= 1'b1;
      s_pix_ready   <= 1'b0;
      m_valid       <= 1'b0;
      cel_done      <= 1'b0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state         <= state_n;
      cfg_ready     <= (state_n == ST_IDLE);
      plut_wr_ready <= (state_n == ST_IDLE);
      s_pix_ready   <= (state_n == ST_LOAD);
      m_valid       <= (state_n == ST_EMIT);
      cel_done      <= (state_n == ST_DONE);
      busy          <= (state_n != ST_IDLE);
      if (cfg_hs)                 err_timeout <= 1'b0;
      else if (cap_tmo && !abort) err_timeout <= 1'b1;
      if (pix_hs)                 wait_cnt <= '0;
      else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Data: latched configuration, pixel stage (_p0) and output register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pdec_cfg      <= '0;
      pdec_pre0     <= '0;
      pdec_pixel    <= '0;
      last_p0       <= 1'b0;
      m_amv         <= '0;
      m_pres        <= '0;
      m_transparent <= 1'b0;
      m_last        <= 1'b0;
    end else begin
      if (cfg_hs) begin
        pdec_cfg  <= cfg_pdec;
        pdec_pre0 <= cfg_pre0;
      end
      if (pix_hs) begin
        pdec_pixel <= s_pix_data;
        last_p0    <= s_pix_last;
      end
      if (capture) begin
        m_amv         <= pdec_amv;
        m_pres        <= pdec_pres;
        m_transparent <= pdec_transparent;
        m_last        <= last_p0;
      end
    end
  end

endmodule

// File: tb/tb_pdec_ctrl.sv
// Self-checking bench for pdec_ctrl with a behavioural pdec stub and PLUT model.
module tb_pdec_ctrl;
  import pdec_defs::*;

  localparam int PDEC_LAT   = 2;
  localparam int TMO_CYCLES = 16;
  localparam int LAT_OK     = PDEC_LAT + 1;
  localparam int LAT_TMO    = PDEC_LAT + TMO_CYCLES + 1;

  logic aclk = 1'b0;
  logic areset;
  logic cfg_valid, cfg_ready;
  pdec  cfg_pdec;
  logic [31:0] cfg_pre0;
  logic plut_wr_en, plut_wr_ready;
  logic [4:0]  plut_wr_addr;
  logic [15:0] plut_wr_data;
  logic s_pix_valid, s_pix_ready, s_pix_last, abort;
  logic [15:0] s_pix_data, pdec_pixel;
  pdec  pdec_cfg;
  logic [31:0] pdec_pre0;
  logic [PLUT_ENTRIES-1:0][15:0] pdec_plut;
  logic pdec_busy, pdec_data_ready, pdec_transparent;
  logic [15:0] pdec_amv, pdec_pres;
  logic m_valid, m_ready, m_transparent, m_last, busy, cel_done, err_timeout;
  logic [15:0] m_amv, m_pres;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hs_cyc = -100;
  int done_cnt = 0;
  logic stub_en = 1'b1;
  logic [15:0] plut_m [PLUT_ENTRIES];

  pdec_ctrl #(.PDEC_LAT(PDEC_LAT), .TMO_CYCLES(TMO_CYCLES)) dut (
    .aclk(aclk), .areset(areset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pdec(cfg_pdec), .cfg_pre0(cfg_pre0),
    .plut_wr_en(plut_wr_en), .plut_wr_addr(plut_wr_addr), .plut_wr_data(plut_wr_data),
    .plut_wr_ready(plut_wr_ready),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready), .s_pix_data(s_pix_data),
    .s_pix_last(s_pix_last), .abort(abort),
    .pdec_pixel(pdec_pixel), .pdec_cfg(pdec_cfg), .pdec_pre0(pdec_pre0), .pdec_plut(pdec_plut),
    .pdec_busy(pdec_busy), .pdec_data_ready(pdec_data_ready),
    .pdec_amv(pdec_amv), .pdec_pres(pdec_pres), .pdec_transparent(pdec_transparent),
    .m_valid(m_valid), .m_ready(m_ready), .m_amv(m_amv), .m_pres(m_pres),
    .m_transparent(m_transparent), .m_last(m_last),
    .busy(busy), .cel_done(cel_done), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  // Stub decoder: results follow the presented pixel, ready PDEC_LAT cycles after its handshake.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (s_pix_valid && s_pix_ready) hs_cyc <= cyc;
    if (cel_done) done_cnt <= done_cnt + 1;
  end
  assign pdec_data_ready  = stub_en && ((cyc - hs_cyc) >= PDEC_LAT);
  assign pdec_amv         = pdec_pixel;
  assign pdec_pres        = pdec_plut[pdec_pixel[4:0]];
  assign pdec_transparent = (pdec_pixel == 16'h0000);
  assign pdec_busy        = busy && !pdec_data_ready;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic plut_write(input logic [4:0] addr, input logic [15:0] data);
    chk("plut_wr_ready_idle", plut_wr_ready, 1);
    plut_wr_en = 1'b1; plut_wr_addr = addr; plut_wr_data = data;
    tick();
    plut_wr_en = 1'b0;
    plut_m[addr] = data;
    chk("plut_entry_written", pdec_plut[addr], plut_m[addr]);
  endtask

  task automatic start_cel(input pdec c, input logic [31:0] pre0);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_pdec = c; cfg_pre0 = pre0;
    tick();
    cfg_valid = 1'b0;
    chk("pdec_cfg", pdec_cfg, c);
    chk("pdec_pre0", pdec_pre0, pre0);
    chk("busy_cel", busy, 1);
    chk("cfg_ready_busy", cfg_ready, 0);
    chk("err_timeout_cleared", err_timeout, 0);
  endtask

  task automatic run_pixel(input logic [15:0] pix, input logic last, input int hold, input int exp_lat);
    int lat;
    logic [15:0] amv0, pres0;
    chk("s_pix_ready_load", s_pix_ready, 1);
    s_pix_valid = 1'b1; s_pix_data = pix; s_pix_last = last;
    tick();
    s_pix_valid = 1'b0; s_pix_last = 1'b0;
    chk("pdec_pixel", pdec_pixel, pix);
    lat = 1;
    while (!m_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("m_valid_latency", lat, exp_lat);
    chk("m_amv", m_amv, pix);
    chk("m_pres", m_pres, plut_m[pix[4:0]]);
    chk("m_transparent", m_transparent, (pix == 16'h0));
    chk("m_last", m_last, last);
    chk("err_timeout", err_timeout, (exp_lat == LAT_TMO));
    amv0 = m_amv; pres0 = m_pres;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_m_valid", m_valid, 1);
      chk("hold_m_amv", m_amv, amv0);
      chk("hold_m_pres", m_pres, pres0);
      chk("hold_s_pix_ready", s_pix_ready, 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("m_valid_after_hs", m_valid, 0);
    if (last) begin
      chk("cel_done_pulse", cel_done, 1);
      tick();
      chk("cel_done_single", cel_done, 0);
      chk("busy_idle", busy, 0);
      chk("cfg_ready_back", cfg_ready, 1);
    end else begin
      chk("s_pix_ready_next", s_pix_ready, 1);
    end
  endtask

  task automatic chk_plut_all(input string tag);
    for (int i = 0; i < PLUT_ENTRIES; i++) chk(tag, pdec_plut[i], plut_m[i]);
  endtask

  initial begin
    int d0, n;
    logic [15:0] pix;
    for (int i = 0; i < PLUT_ENTRIES; i++) plut_m[i] = 16'h0000;
    areset = 1'b1; cfg_valid = 0; cfg_pdec = '0; cfg_pre0 = '0;
    plut_wr_en = 0; plut_wr_addr = '0; plut_wr_data = '0;
    s_pix_valid = 0; s_pix_data = '0; s_pix_last = 0; abort = 0; m_ready = 0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Reset release
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_plut_wr_ready", plut_wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_cel_done", cel_done, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_s_pix_ready", s_pix_ready, 0);
    chk("rst_pdec_pixel", pdec_pixel, 0);
    chk("rst_pdec_pre0", pdec_pre0, 0);
    chk("rst_pdec_cfg", pdec_cfg, 0);
    chk("rst_m_amv", m_amv, 0);
    chk("rst_m_pres", m_pres, 0);
    chk("rst_plut_zero", (pdec_plut == '0), 1);

    // Directed two-pixel cel
    tick();
    plut_write(5'd7, 16'h1CE7);
    plut_write(5'd10, 16'h294A);
    d0 = done_cnt;
    start_cel(pdec'(8'h5A), 32'h804);
    run_pixel(16'h0027, 1'b0, 0, LAT_OK);
    run_pixel(16'h002A, 1'b1, 0, LAT_OK);
    chk("cel_done_count", done_cnt - d0, 1);

    // Back-pressure on the first result
    start_cel(pdec'(8'h13), 32'h1234_5678);
    run_pixel(16'h0027, 1'b0, 5, LAT_OK);
    run_pixel(16'h0000, 1'b1, 0, LAT_OK);

    // Decoder never answers
    stub_en = 1'b0;
    start_cel(pdec'(8'h21), 32'h0);
    run_pixel(16'h004A, 1'b1, 0, LAT_TMO);
    stub_en = 1'b1;
    chk("err_timeout_sticky", err_timeout, 1);
    start_cel(pdec'(8'h22), 32'h1);
    run_pixel(16'h0007, 1'b1, 0, LAT_OK);

    // Abort during WAIT
    start_cel(pdec'(8'h44), 32'hCAFE);
    s_pix_valid = 1'b1; s_pix_data = 16'h0027; s_pix_last = 1'b0;
    tick();
    s_pix_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    d0 = done_cnt;
    chk("abort_busy", busy, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_pre0_kept", pdec_pre0, 32'hCAFE);
    repeat (4) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_m_valid_low", m_valid, 0);
    chk_plut_all("abort_plut_kept");

    // PLUT write attempted during LOAD
    start_cel(pdec'(8'h01), 32'h2);
    plut_wr_en = 1'b1; plut_wr_addr = 5'd7; plut_wr_data = 16'hBEEF;
    chk("plut_wr_ready_load", plut_wr_ready, 0);
    tick();
    plut_wr_en = 1'b0;
    chk("plut_load_unchanged", pdec_plut[7], plut_m[7]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    plut_write(5'd7, 16'hBEEF);

    // Randomized cels against the model
    for (int c = 0; c < 8; c++) begin
      n = $urandom_range(0, 3);
      for (int w = 0; w < n; w++) plut_write(5'($urandom), 16'($urandom));
      start_cel(pdec'($urandom), $urandom);
      n = $urandom_range(1, 4);
      for (int p = 0; p < n; p++) begin
        pix = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        run_pixel(pix, (p == n - 1), $urandom_range(0, 3), LAT_OK);
      end
    end
    chk_plut_all("random_plut");

    // Reset asserted mid-cel
    start_cel(pdec'(8'h7F), 32'hFFFF_0000);
    s_pix_valid = 1'b1; s_pix_data = 16'h1234; s_pix_last = 1'b1;
    tick();
    s_pix_valid = 1'b0; s_pix_last = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_pdec_pixel", pdec_pixel, 0);
    chk("midrst_pdec_pre0", pdec_pre0, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_plut_zero", (pdec_plut == '0), 1);
    tick();
    areset = 1'b0;
    repeat (20) tick();
    chk("midrst_no_emit", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
